// File: rtl/vga_stream_feed.sv
// Pixel-sourcing stage: buffers an SOF-marked pixel stream in a show-ahead FIFO,
// locks it to the sync generator's frame timing and emits phase-aligned RGB/sync.
module vga_stream_feed #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [23:0] FILL_COLOR = 24'h0000FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic        de,
  input  logic [23:0] s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  input  logic        err_clr,
  output logic [23:0] vga_rgb,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        underflow_err,
  output logic        align_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int unsigned PIX_W     = $clog2(FRAME_PIX);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned EW        = 25;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIX - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, wr_addr;
  logic [CW-1:0]    count;
  logic [PIX_W-1:0] pix_cnt;
  logic             vs_d;

  logic [EW-1:0] head;
  logic          head_sof;
  logic          empty, full;
  logic          accept, push, pop, flush;
  logic          vs_fall, align_evt, under_evt, wrap;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign head     = mem[rd_ptr];
  assign head_sof = head[EW-1];

  // A pop in the same cycle does not free a slot for the upstream beat
  assign s_ready = (state_q == HUNT) | ~full;

  assign accept    = s_valid & s_ready;
  assign vs_fall   = vs_d & ~Vsync;
  assign pop       = de & (state_q == RUN) & ~empty;
  assign push      = (state_q == HUNT) ? (s_valid & s_sof) : accept;
  assign flush     = (state_q == HUNT) | ((state_q == ARM) & accept & s_sof);
  assign wr_addr   = flush ? '0 : wr_ptr;
  assign align_evt = pop & ((pix_cnt == '0) != head_sof);
  assign under_evt = de & (state_q == RUN) & empty;
  assign wrap      = pop & (pix_cnt == PIX_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (s_valid & s_sof) state_d = ARM;
      ARM:     if (vs_fall) state_d = RUN;
      RUN:     if (align_evt | under_evt) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // FIFO storage; a flush restarts writing at slot 0
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= {s_sof, s_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push & ~pop)      count <= count + CW'(1);
      else if (pop & ~push) count <= count - CW'(1);
    end
  end

  // Frame position and clean-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (state_q == HUNT) pix_cnt <= '0;
      else if (pop)        pix_cnt <= wrap ? '0 : pix_cnt + PIX_W'(1);
      if (wrap & ~align_evt) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_err <= 1'b0;
      align_err     <= 1'b0;
    end else begin
      if (under_evt)    underflow_err <= 1'b1;
      else if (err_clr) underflow_err <= 1'b0;
      if (align_evt)    align_err <= 1'b1;
      else if (err_clr) align_err <= 1'b0;
    end
  end

  // Output stage keeps RGB and sync phase-aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_rgb <= '0;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
      vga_de  <= 1'b0;
      vs_d    <= 1'b1;
    end else begin
      vga_rgb <= de ? (pop ? head[23:0] : FILL_COLOR) : 24'h0;
      vga_hs  <= Hsync;
      vga_vs  <= Vsync;
      vga_de  <= de;
      vs_d    <= Vsync;
    end
  end

endmodule

// File: tb/tb_vga_stream_feed.sv
// Bench for vga_stream_feed on a shrunken raster, compared every cycle against a
// queue-based model of the stream/frame-lock rules.
module tb_vga_stream_feed;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned N = H * V;
  localparam int unsigned HT = 12;
  localparam int unsigned VT = 7;
  localparam logic [23:0] FILL = 24'h0000FF;
  localparam int M_HUNT = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic Hsync = 1'b1, Vsync = 1'b1, de = 1'b0;
  logic [23:0] s_data = '0;
  logic s_valid = 1'b0, s_sof = 1'b0, err_clr = 1'b0;
  logic s_ready;
  logic [23:0] vga_rgb;
  logic vga_hs, vga_vs, vga_de, underflow_err, align_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  vga_stream_feed #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH), .FILL_COLOR(FILL)
  ) dut (
    .clk(clk), .rst(rst), .Hsync(Hsync), .Vsync(Vsync), .de(de),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
    .err_clr(err_clr), .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .underflow_err(underflow_err), .align_err(align_err),
    .frame_cnt(frame_cnt)
  );

  // model state
  int mode;
  logic [24:0] q[$];
  int pix;
  logic m_vsd, m_hs, m_vs, m_de, m_uf, m_al;
  logic [23:0] m_rgb;
  logic [15:0] m_fc;

  // stimulus state
  logic [24:0] src[$];
  int hold, vprob, clr_prob, bad_pos, hc, vc, rst_cnt;
  bit force_clr, clr_on_und, bad_pending, first_pending, first_de_chk;
  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    mode = M_HUNT; q.delete(); pix = 0; m_vsd = 1'b1;
    m_rgb = '0; m_hs = 1'b1; m_vs = 1'b1; m_de = 1'b0;
    m_uf = 1'b0; m_al = 1'b0; m_fc = '0;
  endfunction

  function automatic bit m_rdy();
    return (mode == M_HUNT) || (q.size() < DEPTH);
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++; errors++;
    $display("FAIL timeout %s actual=expired required=event t=%0t", name, $time);
  endtask

  function automatic void gen_frame();
    logic [24:0] b;
    for (int i = 0; i < N; i++) begin
      b[23:0] = 24'($urandom());
      if (i == 0 && first_pending) begin b[23:0] = 24'hABCDEF; first_pending = 0; end
      b[24] = (i == 0) || (bad_pending && i == bad_pos);
      src.push_back(b);
    end
    bad_pending = 0;
  endfunction

  // One cycle: compare registered outputs, drive next inputs, advance model.
  task automatic step();
    logic [24:0] beat;
    bit rdy, acc, pop, und, aln, vsf, wrap;
    int cur;
    @(negedge clk);
    check1("rgb", vga_rgb, m_rgb);
    check1("hs", vga_hs, m_hs);
    check1("vs", vga_vs, m_vs);
    check1("de", vga_de, m_de);
    check1("underflow_err", underflow_err, m_uf);
    check1("align_err", align_err, m_al);
    check1("frame_cnt", frame_cnt, m_fc);
    check1("s_ready", s_ready, m_rdy());
    if (first_de_chk && vga_de) begin
      check1("first_pixel", vga_rgb, 24'hABCDEF);
      first_de_chk = 0;
    end
    if (rst_cnt > 0) begin
      rst_cnt--;
      if (rst_cnt == 0) rst = 1'b0;
    end
    de    = (hc < H) && (vc < V);
    Hsync = !(hc >= 9 && hc < 11);
    Vsync = (vc != 5);
    hc++;
    if (hc == HT) begin hc = 0; vc = (vc + 1) % VT; end
    if (src.size() == 0) gen_frame();
    if (hold > 0) begin s_valid = 1'b0; hold--; end
    else s_valid = ($urandom_range(99) < vprob);
    {s_sof, s_data} = src[0];
    err_clr = force_clr || ($urandom_range(99) < clr_prob);
    force_clr = 0;
    if (rst) model_reset();
    else begin
      beat = {s_sof, s_data};
      cur  = mode;
      rdy  = m_rdy();
      acc  = s_valid && rdy;
      pop  = de && cur == M_RUN && q.size() > 0;
      und  = de && cur == M_RUN && q.size() == 0;
      aln  = pop && ((pix == 0) != q[0][24]);
      if (clr_on_und && und) err_clr = 1'b1;
      m_rgb = !de ? 24'h0 : (pop ? q[0][23:0] : FILL);
      m_hs = Hsync; m_vs = Vsync; m_de = de;
      vsf = m_vsd && !Vsync;
      m_vsd = Vsync;
      if (pop) begin
        wrap = (pix == N - 1);
        pix  = wrap ? 0 : pix + 1;
        if (wrap && !aln) m_fc++;
        void'(q.pop_front());
      end
      case (cur)
        M_HUNT: begin
          q.delete(); pix = 0;
          if (s_valid && s_sof) begin q.push_back(beat); mode = M_ARM; end
        end
        M_ARM: begin
          if (acc) begin
            if (s_sof) q.delete();
            q.push_back(beat);
          end
          if (vsf) mode = M_RUN;
        end
        default: begin
          if (acc) q.push_back(beat);
          if (und || aln) mode = M_HUNT;
        end
      endcase
      if (und) m_uf = 1'b1; else if (err_clr) m_uf = 1'b0;
      if (aln) m_al = 1'b1; else if (err_clr) m_al = 1'b0;
      if (acc) void'(src.pop_front());
    end
  endtask

  task automatic run_until_fc(input logic [15:0] target, input int budget, input string name);
    int n = 0;
    while (m_fc != target && n < budget) begin step(); n++; end
    if (m_fc != target) timeout(name);
  endtask

  task automatic run_until_uf(input string name);
    int n = 0;
    while (!m_uf && n < 300) begin step(); n++; end
    if (!m_uf) timeout(name);
  endtask

  task automatic run_until_al(input string name);
    int n = 0;
    while (!m_al && n < 500) begin step(); n++; end
    if (!m_al) timeout(name);
  endtask

  task automatic run_until_pos(input int v, input int h);
    int n = 0;
    while (!(vc == v && hc == h) && n < 200) begin step(); n++; end
    if (!(vc == v && hc == h)) timeout("raster_position");
  endtask

  task automatic check_reset_values(input string tag);
    check1({tag, "_rgb"}, vga_rgb, 24'h0);
    check1({tag, "_hs"}, vga_hs, 1'b1);
    check1({tag, "_vs"}, vga_vs, 1'b1);
    check1({tag, "_de"}, vga_de, 1'b0);
    check1({tag, "_s_ready"}, s_ready, 1'b1);
    check1({tag, "_uf"}, underflow_err, 1'b0);
    check1({tag, "_al"}, align_err, 1'b0);
    check1({tag, "_fc"}, frame_cnt, 16'd0);
  endtask

  initial begin
    logic [15:0] target;
    model_reset();
    hc = 0; vc = V; vprob = 100; clr_prob = 0; hold = 0; rst_cnt = 0;
    force_clr = 0; clr_on_und = 0; bad_pending = 0; bad_pos = 10;
    first_pending = 1; first_de_chk = 1;
    for (int i = 0; i < 5; i++) src.push_back({1'b0, 24'($urandom())});

    // reset and clean start with 5 junk beats ahead of the first SOF
    #1 rst = 1'b1;
    #1 check_reset_values("reset");
    rst_cnt = 3;
    run_until_fc(16'd2, 400, "clean_two_frames");
    @(posedge clk); #1;
    check1("clean_frame_cnt", frame_cnt, 16'd2);
    check1("clean_uf", underflow_err, 1'b0);
    check1("clean_al", align_err, 1'b0);

    // underflow mid-line, then recovery on a later frame
    run_until_pos(1, 3);
    hold = 40;
    run_until_uf("underflow");
    @(posedge clk); #1;
    check1("underflow_flag", underflow_err, 1'b1);
    check1("underflow_frame_cnt", frame_cnt, 16'd2);
    run_until_fc(16'd3, 700, "underflow_recovery");
    @(posedge clk); #1;
    check1("recovered_frame_cnt", frame_cnt, 16'd3);

    // stray SOF inside a frame
    bad_pending = 1;
    run_until_al("misalign");
    @(posedge clk); #1;
    check1("align_flag", align_err, 1'b1);
    target = m_fc + 16'd1;
    run_until_fc(target, 700, "realign");
    @(posedge clk); #1;
    check1("realign_frame_cnt", frame_cnt, target);

    // clear alone, then clear colliding with a new underflow, then clear alone
    force_clr = 1;
    step();
    @(posedge clk); #1;
    check1("clr_uf", underflow_err, 1'b0);
    check1("clr_al", align_err, 1'b0);
    clr_on_und = 1;
    run_until_pos(1, 3);
    hold = 40;
    run_until_uf("underflow_with_clear");
    clr_on_und = 0;
    @(posedge clk); #1;
    check1("set_beats_clear", underflow_err, 1'b1);
    repeat (3) step();
    force_clr = 1;
    step();
    @(posedge clk); #1;
    check1("clear_after", underflow_err, 1'b0);

    // randomized valid gaps and clears
    vprob = 85; clr_prob = 3;
    repeat (800) step();
    vprob = 100; clr_prob = 0;

    // reset asserted during active video
    run_until_pos(2, 4);
    step();
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_reset_values("midreset");
    model_reset();
    rst_cnt = 3;
    run_until_fc(16'd1, 700, "post_reset_frame");
    @(posedge clk); #1;
    check1("post_reset_frame_cnt", frame_cnt, 16'd1);
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
